// File: rtl/t_counter.sv
// Modulo-N up/down counter built from toggle-mode state bits, with clear, load,
// wrap/saturate limits, combinational terminal count and a registered overflow pulse.
module t_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QNOT,
  output logic             tc,
  output logic             ovf
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("t_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam bit               SAT = (SATURATE != 0);

  logic             at_max;
  logic             at_zero;
  logic             wrap;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;

  assign at_max  = (Q == MAX);
  assign at_zero = (Q == '0);

  always_comb begin
    q_next = Q;
    wrap   = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap   = 1'b1;
          q_next = SAT ? Q : '0;
        end else begin
          q_next = Q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          wrap   = 1'b1;
          q_next = SAT ? Q : MAX;
        end else begin
          q_next = Q - WIDTH'(1);
        end
      end
    end
  end

  // Each state bit flips only where the next value differs from the current one.
  assign t = Q ^ q_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else begin
      Q   <= Q ^ t;
      ovf <= wrap;
    end
  end

  assign QNOT = ~Q;
  assign tc   = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_t_counter.sv
// Randomised and directed bench for t_counter: several parameterisations plus a
// two-stage decade cascade, all checked every cycle against an arithmetic model.
module tb_t_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] din = 4'd0;
  logic       c_en = 1'b0;

  logic [3:0] q_a, qn_a, q_s, qn_s;
  logic [2:0] q_b, qn_b;
  logic [1:0] q_2, qn_2;
  logic       tc_a, ovf_a, tc_s, ovf_s, tc_b, ovf_b, tc_2, ovf_2;
  logic [3:0] cq0, cqn0, cq1, cqn1;
  logic       ctc0, covf0, ctc1, covf1;

  always #5 clk = ~clk;

  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (.clk(clk), .rst(rst), .en(en), .up(up),
    .clr(clr), .load(load), .din(din), .Q(q_a), .QNOT(qn_a), .tc(tc_a), .ovf(ovf_a));
  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (.clk(clk), .rst(rst), .en(en), .up(up),
    .clr(clr), .load(load), .din(din), .Q(q_s), .QNOT(qn_s), .tc(tc_s), .ovf(ovf_s));
  t_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_b (.clk(clk), .rst(rst), .en(en), .up(up),
    .clr(clr), .load(load), .din(din[2:0]), .Q(q_b), .QNOT(qn_b), .tc(tc_b), .ovf(ovf_b));
  t_counter #(.WIDTH(2), .MODULUS(2), .SATURATE(0)) u_2 (.clk(clk), .rst(rst), .en(en), .up(up),
    .clr(clr), .load(load), .din(din[1:0]), .Q(q_2), .QNOT(qn_2), .tc(tc_2), .ovf(ovf_2));

  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c0 (.clk(clk), .rst(rst), .en(c_en), .up(1'b1),
    .clr(1'b0), .load(1'b0), .din(4'd0), .Q(cq0), .QNOT(cqn0), .tc(ctc0), .ovf(covf0));
  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c1 (.clk(clk), .rst(rst), .en(ctc0), .up(1'b1),
    .clr(1'b0), .load(1'b0), .din(4'd0), .Q(cq1), .QNOT(cqn1), .tc(ctc1), .ovf(covf1));

  localparam int NM = 4;
  int unsigned modv[NM]  = '{10, 10, 8, 2};
  bit          satv[NM]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  int unsigned dmask[NM] = '{15, 15, 7, 3};
  int unsigned mq[NM]    = '{0, 0, 0, 0};
  bit          mo[NM]    = '{1'b0, 1'b0, 1'b0, 1'b0};
  int unsigned mc = 0;
  bit          mo0c = 1'b0, mo1c = 1'b0;

  int n_chk = 0, n_fail = 0, ovf1_cnt = 0;

  function automatic int unsigned step(int unsigned q, int unsigned m, bit sat, int unsigned d,
                                       output bit o);
    o = 1'b0;
    if (clr) return 0;
    if (load) return (d < m) ? d : m - 1;
    if (!en) return q;
    if (up) begin
      if (q + 1 < m) return q + 1;
      o = 1'b1;
      return sat ? q : 0;
    end
    if (q > 0) return q - 1;
    o = 1'b1;
    return sat ? q : m - 1;
  endfunction

  function automatic bit mtc(int i);
    return en && !clr && !load && ((up && mq[i] == modv[i] - 1) || (!up && mq[i] == 0));
  endfunction

  // Reference model: plain modular arithmetic, the cascade as a single 0..99 count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NM; i++) begin
        mq[i] = 0;
        mo[i] = 1'b0;
      end
      mc = 0; mo0c = 1'b0; mo1c = 1'b0;
    end else begin
      for (int i = 0; i < NM; i++)
        mq[i] = step(mq[i], modv[i], satv[i], 32'(din) & dmask[i], mo[i]);
      mo0c = c_en && (mc % 10 == 9);
      mo1c = c_en && (mc == 99);
      if (c_en) mc = (mc + 1) % 100;
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic [3:0] q, logic [3:0] qn, logic o, logic t);
    check($sformatf("Q[%0d]", i), 32'(q), mq[i]);
    check($sformatf("QNOT[%0d]", i), 32'(qn), (~mq[i]) & dmask[i]);
    check($sformatf("ovf[%0d]", i), 32'(o), 32'(mo[i]));
    check($sformatf("tc[%0d]", i), 32'(t), 32'(mtc(i)));
  endtask

  always @(negedge clk) begin
    cmp(0, q_a, qn_a, ovf_a, tc_a);
    cmp(1, q_s, qn_s, ovf_s, tc_s);
    cmp(2, {1'b0, q_b}, {1'b0, qn_b}, ovf_b, tc_b);
    cmp(3, {2'b0, q_2}, {2'b0, qn_2}, ovf_2, tc_2);
    check("casc_q0", 32'(cq0), mc % 10);
    check("casc_q1", 32'(cq1), mc / 10);
    check("casc_qn0", 32'(cqn0), (~(mc % 10)) & 15);
    check("casc_qn1", 32'(cqn1), (~(mc / 10)) & 15);
    check("casc_tc0", 32'(ctc0), 32'(c_en && (mc % 10 == 9)));
    check("casc_tc1", 32'(ctc1), 32'(c_en && (mc == 99)));
    check("casc_ovf0", 32'(covf0), 32'(mo0c));
    check("casc_ovf1", 32'(covf1), 32'(mo1c));
    if (covf1) ovf1_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_hold_q", 32'(q_a), 0);

    // Up-count wrap with literal expectations.
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2)  check("m2_ovf_k2", 32'(ovf_2), 1);
      if (k == 3)  check("m2_ovf_k3", 32'(ovf_2), 0);
      if (k == 8)  begin check("bin_wrap_q", 32'(q_b), 0); check("bin_wrap_ovf", 32'(ovf_b), 1); end
      if (k == 9)  check("up_q9", 32'(q_a), 9);
      if (k == 10) begin
        check("up_wrap_q", 32'(q_a), 0);  check("up_wrap_ovf", 32'(ovf_a), 1);
        check("sat_up_q", 32'(q_s), 9);   check("sat_up_ovf", 32'(ovf_s), 1);
      end
      if (k == 12) begin check("up_q2", 32'(q_a), 2); check("up_q2_ovf", 32'(ovf_a), 0); end
    end

    clr = 1'b1;
    tick();
    check("clr_q", 32'(q_a), 0);
    clr = 1'b0; up = 1'b0;
    tick();
    check("down_wrap_q", 32'(q_a), 9);  check("down_wrap_ovf", 32'(ovf_a), 1);
    check("sat_down_q", 32'(q_s), 0);   check("sat_down_ovf", 32'(ovf_s), 1);

    // Load and clear take priority over counting; tc is suppressed.
    up = 1'b1; load = 1'b1; din = 4'd6;
    tick();
    check("load6_q", 32'(q_a), 6);  check("load6_ovf", 32'(ovf_a), 0);
    din = 4'd13;
    tick();
    check("load13_q", 32'(q_a), 9);
    check("load13_bin_q", 32'(q_b), 5);
    check("load13_m2_q", 32'(q_2), 1);
    #1 check("load_tc_at_max", 32'(tc_a), 0);
    clr = 1'b1; din = 4'd6;
    tick();
    check("clr_load_q", 32'(q_a), 0);
    up = 1'b0;
    #1 check("clr_tc_at_zero", 32'(tc_a), 0);
    clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;

    // Asynchronous reset in the middle of a cycle.
    load = 1'b1; din = 4'd7;
    tick();
    load = 1'b0; en = 1'b1;
    check("pre_rst_q", 32'(q_a), 7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", 32'(q_a), 0);
    check("async_rst_qnot", 32'(qn_a), 32'hF);
    check("async_rst_ovf", 32'(ovf_a), 0);
    en = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_rst_q", 32'(q_a), 0);

    // Two-stage decade cascade.
    ovf1_cnt = 0;
    c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 57) begin check("casc57_q1", 32'(cq1), 5); check("casc57_q0", 32'(cq0), 7); end
    end
    c_en = 1'b0;
    check("casc100_q", 32'({cq1, cq0}), 0);
    @(negedge clk);
    #1 check("casc_ovf1_pulses", 32'(ovf1_cnt), 1);

    // Randomised traffic on every instance.
    for (int k = 0; k < 600; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 9) == 0);
      din  = 4'($urandom_range(0, 15));
      c_en = ($urandom_range(0, 1) != 0);
      tick();
    end
    en = 1'b0; c_en = 1'b0; clr = 1'b0; load = 1'b0;
    tick();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
